program_counter_ras: RTL and testbench

- Parametrised next-generation fetch program counter.
- Width, reset vector and jump-immediate width are configurable.
- Adds an explicit stall, a highest-priority flush/redirect path, and a circular return address stack (RAS) that predicts JR $ra targets at fetch.
- Sits between the hazard/control unit and instruction memory. Drives the fetch address and pc+4 for the link/datapath.

---
 rtl/program_counter_ras_pkg.sv | 17 +
 rtl/program_counter_ras_if.sv | 40 ++++
 rtl/program_counter_ras_ras_stack.sv | 47 ++++
 rtl/program_counter_ras.sv | 111 +++++++++++
 tb/tb_program_counter_ras.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/program_counter_ras_pkg.sv
// Shared types and defaults for the fetch program counter with return-address stack.
package program_counter_ras_pkg;

  localparam int unsigned RAS_DEPTH_DEF = 4;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  // Next-PC source, listed in priority order
  typedef enum logic [2:0] {
    SEL_FLUSH,
    SEL_BR,
    SEL_JR,
    SEL_J,
    SEL_RAS,
    SEL_SEQ
  } pc_sel_t;

endpackage

// File: rtl/program_counter_ras_if.sv
// Signal bundle for program_counter_ras; pc side is the design, tb side drives it.
interface program_counter_ras_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned JIMM_W = 26
) (
  input logic CLK
);
  logic              RST;
  logic              PC_EN;
  logic              flush;
  logic [ADDR_W-1:0] flush_pc;
  logic              PCSrc;
  logic [ADDR_W-1:0] branch_pc;
  logic [ADDR_W-1:0] bimm;
  logic              JR;
  logic [ADDR_W-1:0] jraddr;
  logic              Jump;
  logic [JIMM_W-1:0] jimm;
  logic              link;
  logic [ADDR_W-1:0] link_pc;
  logic              ret_pred;
  logic [ADDR_W-1:0] pcaddr;
  logic [ADDR_W-1:0] nxt_pc;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              ras_full;
  logic              misalign;

  modport pc (
    input  CLK, RST, PC_EN, flush, flush_pc, PCSrc, branch_pc, bimm, JR, jraddr, Jump, jimm,
           link, link_pc, ret_pred,
    output pcaddr, nxt_pc, ras_top, ras_empty, ras_full, misalign
  );

  modport tb (
    input  CLK, pcaddr, nxt_pc, ras_top, ras_empty, ras_full, misalign,
    output RST, PC_EN, flush, flush_pc, PCSrc, branch_pc, bimm, JR, jraddr, Jump, jimm,
           link, link_pc, ret_pred
  );
endinterface

// File: rtl/program_counter_ras_ras_stack.sv
// Circular return-address stack; overflow overwrites the oldest entry, push+pop replaces top.
module ras_stack
  import program_counter_ras_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
);
  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [PW-1:0]     r_tp;
  logic [CW-1:0]     r_cnt;
  logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]     w_tp_inc;

  assign w_tp_inc = r_tp + PW'(1);
  assign empty    = (r_cnt == '0);
  assign full     = (r_cnt == CW'(RAS_DEPTH));
  assign top      = empty ? '0 : r_mem[r_tp];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) r_mem[i] <= '0;
    end else if (push && pop && !empty) begin
      r_mem[r_tp] <= push_data;
    end else if (push) begin
      r_tp            <= w_tp_inc;
      r_mem[w_tp_inc] <= push_data;
      if (!full) r_cnt <= r_cnt + CW'(1);
    end else if (pop && !empty) begin
      r_tp  <= r_tp - PW'(1);
      r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/program_counter_ras.sv
// Fetch PC with stall, priority redirect mux and return-address prediction.
// Optional: PC_MISALIGN_TRAP_EN traps misaligned targets to RESET_PC and pulses misalign.
module program_counter_ras
  import program_counter_ras_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_PC_DEF),
  parameter int unsigned       JIMM_W    = 26,
  parameter int unsigned       RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PC_EN,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              PCSrc,
  input  logic [ADDR_W-1:0] branch_pc,
  input  logic [ADDR_W-1:0] bimm,
  input  logic              JR,
  input  logic [ADDR_W-1:0] jraddr,
  input  logic              Jump,
  input  logic [JIMM_W-1:0] jimm,
  input  logic              link,
  input  logic [ADDR_W-1:0] link_pc,
  input  logic              ret_pred,
  output logic [ADDR_W-1:0] pcaddr,
  output logic [ADDR_W-1:0] nxt_pc,
  output logic [ADDR_W-1:0] ras_top,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              misalign
);
  // Bits of pcaddr replaced by {jimm, 2'b00} on a J/JAL
  localparam logic [ADDR_W-1:0] JMASK = {ADDR_W{1'b1}} >> (ADDR_W - JIMM_W - 2);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_d;
  logic [ADDR_W-1:0] w_sel_pc;
  logic [ADDR_W-1:0] w_jump_pc;
  pc_sel_t           w_sel;
  logic              w_upd;
  logic              w_push;
  logic              w_pop;

  assign pcaddr    = r_pc;
  assign nxt_pc    = r_pc + ADDR_W'(4);
  assign w_jump_pc = (r_pc & ~JMASK) | ADDR_W'({jimm, 2'b00});
  // flush redirects even while stalled; the stack only moves on enabled, non-flushed cycles
  assign w_upd     = PC_EN | flush;
  assign w_push    = PC_EN & link & ~flush;
  assign w_pop     = PC_EN & (w_sel == SEL_RAS);

  always_comb begin
    w_sel = SEL_SEQ;
    if (flush)                       w_sel = SEL_FLUSH;
    else if (PCSrc)                  w_sel = SEL_BR;
    else if (JR)                     w_sel = SEL_JR;
    else if (Jump)                   w_sel = SEL_J;
    else if (ret_pred && !ras_empty) w_sel = SEL_RAS;
  end

  always_comb begin
    w_sel_pc = nxt_pc;
    unique case (w_sel)
      SEL_FLUSH: w_sel_pc = flush_pc;
      SEL_BR:    w_sel_pc = branch_pc + (bimm << 2);
      SEL_JR:    w_sel_pc = jraddr;
      SEL_J:     w_sel_pc = w_jump_pc;
      SEL_RAS:   w_sel_pc = ras_top;
      SEL_SEQ:   w_sel_pc = nxt_pc;
      default:   w_sel_pc = nxt_pc;
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic w_mis;
  logic r_misalign;

  assign w_mis    = (w_sel_pc[1:0] != 2'b00);
  assign w_pc_d   = w_mis ? RESET_PC : w_sel_pc;
  assign misalign = r_misalign;

  always_ff @(posedge CLK) begin
    if (RST) r_misalign <= 1'b0;
    else     r_misalign <= w_upd & w_mis;
  end
`else
  assign w_pc_d   = w_sel_pc & ~ADDR_W'(3);
  assign misalign = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST)        r_pc <= RESET_PC;
    else if (w_upd) r_pc <= w_pc_d;
  end

  ras_stack #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .CLK      (CLK),
    .RST      (RST),
    .push     (w_push),
    .pop      (w_pop),
    .push_data(link_pc),
    .top      (ras_top),
    .empty    (ras_empty),
    .full     (ras_full)
  );

endmodule

// File: tb/tb_program_counter_ras.sv
// Scoreboard bench for program_counter_ras (RESET_PC=0x400, depth 4).
module tb_program_counter_ras;

  typedef struct packed {
    logic        rst, pc_en, flush, pcsrc, jr, jump, link, ret;
    logic [31:0] flush_pc, branch_pc, bimm, jraddr, link_pc;
    logic [25:0] jimm;
  } stim_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] top;
    logic        empty, full, mis;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  program_counter_ras_if #(.ADDR_W(32), .JIMM_W(26)) pif (.CLK(clk));

  program_counter_ras #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0400),
    .JIMM_W   (26),
    .RAS_DEPTH(4)
  ) dut (
    .CLK      (clk),
    .RST      (pif.RST),
    .PC_EN    (pif.PC_EN),
    .flush    (pif.flush),
    .flush_pc (pif.flush_pc),
    .PCSrc    (pif.PCSrc),
    .branch_pc(pif.branch_pc),
    .bimm     (pif.bimm),
    .JR       (pif.JR),
    .jraddr   (pif.jraddr),
    .Jump     (pif.Jump),
    .jimm     (pif.jimm),
    .link     (pif.link),
    .link_pc  (pif.link_pc),
    .ret_pred (pif.ret_pred),
    .pcaddr   (pif.pcaddr),
    .nxt_pc   (pif.nxt_pc),
    .ras_top  (pif.ras_top),
    .ras_empty(pif.ras_empty),
    .ras_full (pif.ras_full),
    .misalign (pif.misalign)
  );

  int   n_vec = 0;
  int   n_err = 0;
  obs_t exp_q[$];

  function automatic stim_t idle();
    stim_t s = '0;
    s.pc_en = 1'b1;
    return s;
  endfunction

  function automatic obs_t ob(logic [31:0] pc, logic [31:0] top, logic e, logic f, logic m);
    obs_t o;
    o.pc = pc; o.top = top; o.empty = e; o.full = f; o.mis = m;
    return o;
  endfunction

  function automatic obs_t observe();
    return ob(pif.pcaddr, pif.ras_top, pif.ras_empty, pif.ras_full, pif.misalign);
  endfunction

  task automatic drive(input stim_t s);
    pif.RST = s.rst;   pif.PC_EN = s.pc_en;       pif.flush = s.flush;
    pif.flush_pc = s.flush_pc; pif.PCSrc = s.pcsrc; pif.branch_pc = s.branch_pc;
    pif.bimm = s.bimm; pif.JR = s.jr;             pif.jraddr = s.jraddr;
    pif.Jump = s.jump; pif.jimm = s.jimm;         pif.link = s.link;
    pif.link_pc = s.link_pc; pif.ret_pred = s.ret;
  endtask

  task automatic test_reset();
    stim_t sq[$]; obs_t eq[$]; stim_t s; obs_t got, want;
    s = idle(); s.rst = 1; s.pc_en = 0;      sq.push_back(s); eq.push_back(ob(32'h400, 0, 1, 0, 0));
    s = idle();                              sq.push_back(s); eq.push_back(ob(32'h404, 0, 1, 0, 0));
                                             sq.push_back(s); eq.push_back(ob(32'h408, 0, 1, 0, 0));
                                             sq.push_back(s); eq.push_back(ob(32'h40C, 0, 1, 0, 0));
    s = idle(); s.rst = 1;                   sq.push_back(s); eq.push_back(ob(32'h400, 0, 1, 0, 0));
    s.flush = 1; s.flush_pc = 32'h80;        sq.push_back(s); eq.push_back(ob(32'h400, 0, 1, 0, 0));
    s = idle(); s.pc_en = 0;                 sq.push_back(s); eq.push_back(ob(32'h400, 0, 1, 0, 0));
    foreach (sq[i]) begin
      drive(sq[i]); exp_q.push_back(eq[i]);
      @(posedge clk); #1;
      got = observe(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL reset[%0d]: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_priority();
    stim_t sq[$]; obs_t eq[$]; stim_t s; obs_t got, want;
    s = idle(); s.flush = 1; s.flush_pc = 32'h80; s.pcsrc = 1; s.branch_pc = 32'h100;
    s.bimm = 32'hFFFF_FFFF; s.jr = 1; s.jraddr = 32'h3000_2000; s.jump = 1; s.jimm = 26'h40;
    sq.push_back(s); eq.push_back(ob(32'h80, 0, 1, 0, 0));
    s.flush = 0;     sq.push_back(s); eq.push_back(ob(32'hFC, 0, 1, 0, 0));
    s.pcsrc = 0;     sq.push_back(s); eq.push_back(ob(32'h3000_2000, 0, 1, 0, 0));
    s.jr = 0;        sq.push_back(s); eq.push_back(ob(32'h3000_0100, 0, 1, 0, 0));
    s = idle();      sq.push_back(s); eq.push_back(ob(32'h3000_0104, 0, 1, 0, 0));
    s.pc_en = 0; s.flush = 1; s.flush_pc = 32'h200; s.pcsrc = 1; s.branch_pc = 32'h500;
    s.bimm = 32'h1;  sq.push_back(s); eq.push_back(ob(32'h200, 0, 1, 0, 0));
    s.flush = 0;     sq.push_back(s); eq.push_back(ob(32'h200, 0, 1, 0, 0));
    foreach (sq[i]) begin
      drive(sq[i]); exp_q.push_back(eq[i]);
      @(posedge clk); #1;
      got = observe(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL priority[%0d]: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_ras_overflow();
    stim_t sq[$]; obs_t eq[$]; stim_t s; obs_t got, want;
    logic [31:0] pcs [5] = '{32'h204, 32'h208, 32'h20C, 32'h210, 32'h214};
    logic [31:0] rets [4] = '{32'h50, 32'h40, 32'h30, 32'h20};
    for (int k = 0; k < 5; k++) begin
      s = idle(); s.link = 1; s.link_pc = 32'(16 * (k + 1));
      sq.push_back(s);
      eq.push_back(ob(pcs[k], 32'(16 * (k + 1)), 0, (k >= 3), 0));
    end
    for (int k = 0; k < 4; k++) begin
      s = idle(); s.ret = 1;
      sq.push_back(s);
      eq.push_back(ob(rets[k], (k == 3) ? 32'h0 : rets[k] - 32'h10, (k == 3), 0, 0));
    end
    s = idle(); s.ret = 1; sq.push_back(s); eq.push_back(ob(32'h24, 0, 1, 0, 0));
    foreach (sq[i]) begin
      drive(sq[i]); exp_q.push_back(eq[i]);
      @(posedge clk); #1;
      got = observe(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL ras_overflow[%0d]: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_push_pop_same();
    stim_t sq[$]; obs_t eq[$]; stim_t s; obs_t got, want;
    s = idle(); s.link = 1; s.link_pc = 32'h10; sq.push_back(s); eq.push_back(ob(32'h28, 32'h10, 0, 0, 0));
    s.link_pc = 32'h20;                         sq.push_back(s); eq.push_back(ob(32'h2C, 32'h20, 0, 0, 0));
    s.link_pc = 32'h99; s.ret = 1;              sq.push_back(s); eq.push_back(ob(32'h20, 32'h99, 0, 0, 0));
    s = idle(); s.ret = 1;
`ifdef PC_MISALIGN_TRAP_EN
    sq.push_back(s); eq.push_back(ob(32'h400, 32'h10, 0, 0, 1));
`else
    sq.push_back(s); eq.push_back(ob(32'h98, 32'h10, 0, 0, 0));
`endif
    sq.push_back(s); eq.push_back(ob(32'h10, 0, 1, 0, 0));
    foreach (sq[i]) begin
      drive(sq[i]); exp_q.push_back(eq[i]);
      @(posedge clk); #1;
      got = observe(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL push_pop_same[%0d]: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_stall();
    stim_t sq[$]; obs_t eq[$]; stim_t s; obs_t got, want;
    s = idle(); s.link = 1; s.link_pc = 32'h70; sq.push_back(s); eq.push_back(ob(32'h14, 32'h70, 0, 0, 0));
    s.pc_en = 0; s.link_pc = 32'hAA; s.ret = 1;
    for (int k = 0; k < 5; k++) begin
      sq.push_back(s); eq.push_back(ob(32'h14, 32'h70, 0, 0, 0));
    end
    s = idle(); s.ret = 1; sq.push_back(s); eq.push_back(ob(32'h70, 0, 1, 0, 0));
    foreach (sq[i]) begin
      drive(sq[i]); exp_q.push_back(eq[i]);
      @(posedge clk); #1;
      got = observe(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL stall[%0d]: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_wrap();
    stim_t s; obs_t got, want;
    s = idle(); s.flush = 1; s.flush_pc = 32'hFFFF_FFFC;
    drive(s); exp_q.push_back(ob(32'hFFFF_FFFC, 0, 1, 0, 0));
    @(posedge clk); #1;
    got = observe(); want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL wrap_load: got %h want %h", got, want);
    end
    n_vec++;
    if (pif.nxt_pc !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_nxt_pc: got %h want 00000000", pif.nxt_pc);
    end
    s = idle(); drive(s); exp_q.push_back(ob(32'h0, 0, 1, 0, 0));
    @(posedge clk); #1;
    got = observe(); want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL wrap_step: got %h want %h", got, want);
    end
  endtask

  task automatic test_misalign();
    stim_t sq[$]; obs_t eq[$]; stim_t s; obs_t got, want;
    s = idle(); s.jr = 1; s.jraddr = 32'h1002; sq.push_back(s);
`ifdef PC_MISALIGN_TRAP_EN
    eq.push_back(ob(32'h400, 0, 1, 0, 1));
    s = idle(); sq.push_back(s); eq.push_back(ob(32'h404, 0, 1, 0, 0));
`else
    eq.push_back(ob(32'h1000, 0, 1, 0, 0));
    s = idle(); sq.push_back(s); eq.push_back(ob(32'h1004, 0, 1, 0, 0));
`endif
    foreach (sq[i]) begin
      drive(sq[i]); exp_q.push_back(eq[i]);
      @(posedge clk); #1;
      got = observe(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL misalign[%0d]: got %h want %h", i, got, want);
      end
    end
  endtask

  initial begin
    stim_t s;
    s = idle(); s.rst = 1; s.pc_en = 0;
    drive(s);
    test_reset();
    test_priority();
    test_ras_overflow();
    test_push_pop_same();
    test_stall();
    test_wrap();
    test_misalign();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
